ultrasonic_ranger: RTL

Upstream sensor stage for the PID register file. It periodically fires an ultrasonic ranging sensor (trigger pulse, echo-width measurement), converts the echo width to distance units and delivers a 16-bit sample with a one-cycle ready strobe. Its outputs drive the register file's sensor-data and sensor-ready inputs. The file captures the sample into the read-only sensor register.

---
 rtl/ultrasonic_ranger.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranging front-end: fires the sensor trigger periodically,
// times the echo pulse and delivers a 16-bit distance sample with a strobe.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TICKS_PER_UNIT = 2900,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int PERIOD_CYCLES  = 3000000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        echo_i,
    output logic        trig_o,
    output logic [15:0] sens_data_o,
    output logic        sens_data_rdy_o,
    output logic        timeout_o
);

    localparam int TRW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PDW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int SBW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

    localparam logic [TRW-1:0] TRIG_LAST = TRW'(TRIG_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [PDW-1:0] PER_LAST  = PDW'(PERIOD_CYCLES - 1);
    localparam logic [PDW-1:0] PER_MAX   = '1;
    localparam logic [SBW-1:0] SUB_LAST  = SBW'(TICKS_PER_UNIT - 1);

    // The echo rise cycle already counts as one echo-high cycle, so the
    // sub-counter and accumulator are seeded with one tick's worth.
    localparam logic [SBW-1:0] SUB_FIRST =
        SBW'((TICKS_PER_UNIT > 1) ? 1 : 0);
    localparam logic [15:0]    ACC_FIRST =
        16'((TICKS_PER_UNIT > 1) ? 0 : 1);
    localparam bit             TO_ONE    = (TIMEOUT_CYCLES <= 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4,
        HOLDOFF   = 3'd5
    } state_t;

    state_t         state;
    logic           echo_meta;
    logic           echo_s;
    logic           echo_d;
    logic           echo_rise;
    logic [TRW-1:0] trig_cnt;
    logic [TOW-1:0] to_cnt;
    logic [PDW-1:0] period_cnt;
    logic [SBW-1:0] sub_cnt;
    logic [15:0]    acc;
    logic [SBW-1:0] sub_next;
    logic [15:0]    acc_next;

    // Two-flop echo synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo_i;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;

    // Advance the distance count by one echo-high cycle, saturating.
    always_comb begin
        sub_next = sub_cnt + SBW'(1);
        acc_next = acc;
        if (sub_cnt == SUB_LAST) begin
            sub_next = '0;
            if (acc != 16'hFFFF) begin
                acc_next = acc + 16'd1;
            end
        end
    end

    // Measurement sequencer with registered trigger and sample outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state           <= IDLE;
            trig_o          <= 1'b0;
            sens_data_o     <= '0;
            sens_data_rdy_o <= 1'b0;
            timeout_o       <= 1'b0;
            trig_cnt        <= '0;
            to_cnt          <= '0;
            period_cnt      <= '0;
            sub_cnt         <= '0;
            acc             <= '0;
        end else if (!enable_i && state != IDLE) begin
            state           <= IDLE;
            trig_o          <= 1'b0;
            sens_data_rdy_o <= 1'b0;
            trig_cnt        <= '0;
            to_cnt          <= '0;
            period_cnt      <= '0;
            sub_cnt         <= '0;
            acc             <= '0;
        end else begin
            sens_data_rdy_o <= 1'b0;
            if (state != IDLE && period_cnt != PER_MAX) begin
                period_cnt <= period_cnt + PDW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        state      <= TRIG;
                        trig_o     <= 1'b1;
                        trig_cnt   <= '0;
                        period_cnt <= '0;
                    end
                end
                TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        state  <= WAIT_ECHO;
                        trig_o <= 1'b0;
                        to_cnt <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + TRW'(1);
                    end
                end
                WAIT_ECHO: begin
                    if (echo_rise && !TO_ONE) begin
                        state   <= MEASURE;
                        to_cnt  <= TOW'(1);
                        sub_cnt <= SUB_FIRST;
                        acc     <= ACC_FIRST;
                    end else if (echo_rise || to_cnt == TO_LAST) begin
                        state           <= DONE;
                        sens_data_rdy_o <= 1'b1;
                        sens_data_o     <= 16'hFFFF;
                        timeout_o       <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        state           <= DONE;
                        sens_data_rdy_o <= 1'b1;
                        sens_data_o     <= acc;
                        timeout_o       <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state           <= DONE;
                        sens_data_rdy_o <= 1'b1;
                        sens_data_o     <= 16'hFFFF;
                        timeout_o       <= 1'b1;
                    end else begin
                        to_cnt  <= to_cnt + TOW'(1);
                        sub_cnt <= sub_next;
                        acc     <= acc_next;
                    end
                end
                DONE: begin
                    state <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (period_cnt >= PER_LAST) begin
                        state      <= TRIG;
                        trig_o     <= 1'b1;
                        trig_cnt   <= '0;
                        period_cnt <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    trig_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
